// File: rtl/multi_port_frame_generator_if.sv
// multi_port_frame_generator_if: beat bus between the frame generator and the NoC fabric
interface multi_port_frame_generator_if #(
    parameter int AVL_DATA_WIDTH = 518,
    parameter int FRAME_ID_WIDTH = 32
);
    localparam int WIDTH_PKT = AVL_DATA_WIDTH + 2 + FRAME_ID_WIDTH;
    logic [WIDTH_PKT-1:0] noc_data_in;
    logic [3:0]           noc_valid_in;
    logic [3:0]           noc_sop_in;
    logic [3:0]           noc_eop_in;
    logic                 noc_ready_out;
    modport master (output noc_data_in, noc_valid_in, noc_sop_in, noc_eop_in, input noc_ready_out);
    modport slave  (input noc_data_in, noc_valid_in, noc_sop_in, noc_eop_in, output noc_ready_out);
endinterface

// File: rtl/multi_port_frame_generator.sv
// multi_port_frame_generator: round-robin multi-port test frame source with gap, length modes and frame limit
module multi_port_frame_generator #(
    parameter int AVL_DATA_WIDTH     = 518,
    parameter int FRAME_ID_WIDTH     = 32,
    parameter int NUM_PORTS          = 4,
    parameter int FRAME_OFFSET_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [FRAME_OFFSET_WIDTH-1:0] cfg_len,
    input  logic                          cfg_len_mode,
    input  logic [3:0]                    cfg_gap,
    input  logic [15:0]                   cfg_frame_limit,
    multi_port_frame_generator_if.master  noc,
    output logic [15:0]                   frames_sent,
    output logic                          done
);
    localparam int PORT_ID_WIDTH = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
    localparam int SEQ_WIDTH     = FRAME_ID_WIDTH - PORT_ID_WIDTH;
    localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2, DONE = 2'd3;

    logic [1:0]                    state;
    logic [FRAME_OFFSET_WIDTH-1:0] beat, len_q, inc_last, last;
    logic                          mode_q;
    logic [3:0]                    gap_q, gap_cnt;
    logic [PORT_ID_WIDTH-1:0]      port, port_next;
    logic [SEQ_WIDTH-1:0]          seq [NUM_PORTS];
    logic [SEQ_WIDTH-1:0]          seq_cur;
    logic [15:0]                   fs_next;
    logic                          limit_hit, hit_next, send;
    logic [31:0]                   word;
    logic [AVL_DATA_WIDTH-1:0]     payload;

    assign last      = mode_q ? inc_last : len_q;
    assign seq_cur   = seq[port];
    assign port_next = port == PORT_ID_WIDTH'(NUM_PORTS - 1) ? '0 : port + 1'b1;
    assign fs_next   = frames_sent + {15'd0, ~&frames_sent};
    assign limit_hit = cfg_frame_limit != 16'd0 && frames_sent == cfg_frame_limit;
    assign hit_next  = cfg_frame_limit != 16'd0 && fs_next == cfg_frame_limit;
    assign send      = state == SEND;
    assign word      = {8'(beat), 16'(seq_cur), 8'(port)};

    // replicate the 32-bit tag word across the payload, truncated to the payload width
    always_comb begin
        payload = '0;
        for (int i = 0; i < AVL_DATA_WIDTH; i++) payload[i] = word[i % 32];
    end

    // beat outputs are pure functions of registered state so they stay put while the fabric stalls
    always_comb begin
        noc.noc_valid_in = send ? 4'b1111 : 4'b0000;
        noc.noc_sop_in   = send && beat == '0 ? 4'b0001 : 4'b0000;
        noc.noc_eop_in   = send && beat == last ? 4'b1000 : 4'b0000;
        noc.noc_data_in  = send ? {port, seq_cur, beat == '0, beat == last, payload} : '0;
        done             = state == DONE;
    end

    // frame sequencing: config latch on start, beat advance on accept, per-port bookkeeping at frame end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            beat        <= '0;
            len_q       <= '0;
            inc_last    <= '0;
            mode_q      <= 1'b0;
            gap_q       <= '0;
            gap_cnt     <= '0;
            port        <= '0;
            frames_sent <= '0;
            for (int i = 0; i < NUM_PORTS; i++) seq[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (limit_hit) state <= DONE;
                    else if (enable) begin
                        state  <= SEND;
                        len_q  <= cfg_len;
                        mode_q <= cfg_len_mode;
                        gap_q  <= cfg_gap;
                        beat   <= '0;
                    end
                end
                SEND: begin
                    if (noc.noc_ready_out) begin
                        if (beat == last) begin
                            beat        <= '0;
                            frames_sent <= fs_next;
                            seq[port]   <= seq_cur + 1'b1;
                            port        <= port_next;
                            inc_last    <= inc_last >= len_q ? '0 : inc_last + 1'b1;
                            gap_cnt     <= gap_q;
                            state       <= hit_next ? DONE : gap_q != 4'd0 ? GAP : enable ? SEND : IDLE;
                        end else beat <= beat + 1'b1;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 1'b1;
                    if (gap_cnt == 4'd1) state <= enable ? SEND : IDLE;
                end
                default: state <= DONE;
            endcase
        end
    end
endmodule

// File: tb/tb_multi_port_frame_generator.sv
// tb_multi_port_frame_generator: directed scoreboard bench for the frame generator
module tb_multi_port_frame_generator;
    localparam int ADW = 518;
    localparam int FIW = 32;
    localparam int PIW = 2;
    localparam int SQW = FIW - PIW;
    localparam int WP  = ADW + 2 + FIW;

    typedef struct {
        logic [WP-1:0] d;
        logic [3:0]    sop;
        logic [3:0]    eop;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [4:0]  cfg_len = '0;
    logic        cfg_len_mode = 1'b0;
    logic [3:0]  cfg_gap = '0;
    logic [15:0] cfg_frame_limit = '0;
    logic [15:0] frames_sent;
    logic        done;

    int n_checks = 0, n_fail = 0, n_xfer = 0, cyc = 0, first_x = -1, last_x = -1;
    bit hold = 0;
    logic [WP+11:0] snap;
    beat_t sb[$];

    multi_port_frame_generator_if #(.AVL_DATA_WIDTH(ADW), .FRAME_ID_WIDTH(FIW)) nif ();

    multi_port_frame_generator dut (
        .clk(clk), .rst(rst), .enable(enable), .cfg_len(cfg_len), .cfg_len_mode(cfg_len_mode),
        .cfg_gap(cfg_gap), .cfg_frame_limit(cfg_frame_limit), .noc(nif.master),
        .frames_sent(frames_sent), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WP-1:0] exp_pkt(int p, int s, int b, bit sof, bit eof);
        logic [31:0]    w;
        logic [ADW-1:0] pl;
        w = {8'(b), 16'(s), 8'(p)};
        for (int i = 0; i < ADW; i++) pl[i] = w[i % 32];
        return {PIW'(p), SQW'(s), sof, eof, pl};
    endfunction

    task automatic push_frame(int p, int s, int len);
        for (int b = 0; b < len; b++)
            sb.push_back('{exp_pkt(p, s, b, b == 0, b == len - 1),
                           b == 0 ? 4'b0001 : 4'b0000, b == len - 1 ? 4'b1000 : 4'b0000});
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b0;
        nif.noc_ready_out = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        n_xfer = 0;
        first_x = -1;
        last_x = -1;
    endtask

    task automatic wait_done(int budget);
        for (int i = 0; i < budget && !done; i++) @(negedge clk);
        chk("done_reached", 32'(done), 32'd1);
    endtask

    // monitor: scoreboard pop on every accepted beat, plus stall stability check
    always @(negedge clk) begin
        #1;
        if (!rst) hold = 0;
        else begin
            if (hold) begin
                n_checks++;
                if ({nif.noc_valid_in, nif.noc_sop_in, nif.noc_eop_in, nif.noc_data_in} !== snap) begin
                    n_fail++;
                    $display("FAIL stall_stable: outputs changed during ready=0, now valid=%h sop=%h eop=%h",
                             nif.noc_valid_in, nif.noc_sop_in, nif.noc_eop_in);
                end
            end
            hold = |nif.noc_valid_in && !nif.noc_ready_out;
            snap = {nif.noc_valid_in, nif.noc_sop_in, nif.noc_eop_in, nif.noc_data_in};
            if (|nif.noc_valid_in && nif.noc_ready_out) begin
                beat_t e;
                n_xfer++;
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat_unexpected: got id=%h sop=%h eop=%h with nothing expected",
                             nif.noc_data_in[WP-1 -: FIW], nif.noc_sop_in, nif.noc_eop_in);
                end else begin
                    e = sb.pop_front();
                    if ({nif.noc_valid_in, nif.noc_sop_in, nif.noc_eop_in, nif.noc_data_in} !==
                        {4'b1111, e.sop, e.eop, e.d}) begin
                        n_fail++;
                        $display("FAIL beat: got v=%h s=%h e=%h d=%h expected v=f s=%h e=%h d=%h",
                                 nif.noc_valid_in, nif.noc_sop_in, nif.noc_eop_in, nif.noc_data_in,
                                 e.sop, e.eop, e.d);
                    end
                end
            end
        end
    end

    initial begin
        logic [9:0] vbits;
        nif.noc_ready_out = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(nif.noc_valid_in), 32'd0);
        chk("rst_sop_eop", 32'({nif.noc_sop_in, nif.noc_eop_in}), 32'd0);
        chk("rst_data_zero", 32'(|nif.noc_data_in), 32'd0);
        chk("rst_frames_sent", 32'(frames_sent), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b1;

        // fixed 4-beat frames, four ports, back to back
        do_reset();
        cfg_len = 5'd3; cfg_len_mode = 1'b0; cfg_gap = 4'd0; cfg_frame_limit = 16'd4;
        for (int p = 0; p < 4; p++) push_frame(p, 0, 4);
        enable = 1'b1;
        wait_done(100);
        chk("fixed_frames_sent", 32'(frames_sent), 32'd4);
        chk("fixed_beats", 32'(n_xfer), 32'd16);
        chk("fixed_no_bubble", 32'(last_x - first_x), 32'd15);
        chk("done_valid_low", 32'(nif.noc_valid_in), 32'd0);
        chk("fixed_sb_empty", 32'(sb.size()), 32'd0);

        // ready toggling every cycle
        do_reset();
        cfg_len = 5'd1; cfg_frame_limit = 16'd2;
        push_frame(0, 0, 2);
        push_frame(1, 0, 2);
        nif.noc_ready_out = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            nif.noc_ready_out = ~nif.noc_ready_out;
        end
        nif.noc_ready_out = 1'b1;
        chk("toggle_done", 32'(done), 32'd1);
        chk("toggle_beats", 32'(n_xfer), 32'd4);
        chk("toggle_frames_sent", 32'(frames_sent), 32'd2);
        chk("toggle_sb_empty", 32'(sb.size()), 32'd0);

        // incrementing lengths 1,2,3,1,2
        do_reset();
        cfg_len = 5'd2; cfg_len_mode = 1'b1; cfg_frame_limit = 16'd5;
        push_frame(0, 0, 1);
        push_frame(1, 0, 2);
        push_frame(2, 0, 3);
        push_frame(3, 0, 1);
        push_frame(0, 1, 2);
        enable = 1'b1;
        wait_done(100);
        chk("inc_beats", 32'(n_xfer), 32'd9);
        chk("inc_frames_sent", 32'(frames_sent), 32'd5);
        chk("inc_sb_empty", 32'(sb.size()), 32'd0);

        // three idle cycles between two 2-beat frames
        do_reset();
        cfg_len = 5'd1; cfg_len_mode = 1'b0; cfg_gap = 4'd3; cfg_frame_limit = 16'd2;
        push_frame(0, 0, 2);
        push_frame(1, 0, 2);
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1 vbits[i] = |nif.noc_valid_in;
        end
        chk("gap_valid_pattern", 32'(vbits), 32'b0001100011);
        chk("gap_done", 32'(done), 32'd1);
        chk("gap_sb_empty", 32'(sb.size()), 32'd0);

        // enable dropped on beat 1 of a 4-beat frame
        do_reset();
        cfg_len = 5'd3; cfg_gap = 4'd0; cfg_frame_limit = 16'd0;
        push_frame(0, 0, 4);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        enable = 1'b0;
        repeat (8) @(negedge clk);
        chk("drop_frames_sent", 32'(frames_sent), 32'd1);
        chk("drop_idle_valid", 32'(nif.noc_valid_in), 32'd0);
        chk("drop_done", 32'(done), 32'd0);
        chk("drop_sb_empty", 32'(sb.size()), 32'd0);

        // reset in the middle of the fourth frame
        do_reset();
        cfg_len = 5'd3; cfg_frame_limit = 16'd0;
        for (int p = 0; p < 3; p++) push_frame(p, 0, 4);
        sb.push_back('{exp_pkt(3, 0, 0, 1'b1, 1'b0), 4'b0001, 4'b0000});
        enable = 1'b1;
        repeat (14) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(nif.noc_valid_in), 32'd0);
        chk("midrst_data_zero", 32'(|nif.noc_data_in), 32'd0);
        chk("midrst_sb_empty", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
        cfg_frame_limit = 16'd1;
        rst = 1'b1;
        #1;
        chk("midrst_frames_sent", 32'(frames_sent), 32'd0);
        push_frame(0, 0, 4);
        wait_done(50);
        chk("midrst_frames_after", 32'(frames_sent), 32'd1);
        chk("midrst_sb_after", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
